// File: rtl/riscv_alu_queue_if_if.sv
// AHB-lite slave bus bundle for the queued ALU coprocessor.
// The master modport drives the request side, the slave modport returns ready/resp/rdata.
interface riscv_alu_queue_if_if #(
    parameter int unsigned W_ADDR  = 32,
    parameter int unsigned W_DATA  = 32,
    parameter int unsigned W_TRANS = 2,
    parameter int unsigned W_BURST = 3,
    parameter int unsigned W_SIZE  = 3,
    parameter int unsigned W_RESP  = 2
);
    logic                sl_HSEL;
    logic                sl_HREADY;
    logic                sl_HWRITE;
    logic [W_TRANS-1:0]  sl_HTRANS;
    logic [W_BURST-1:0]  sl_HBURST;
    logic [W_SIZE-1:0]   sl_HSIZE;
    logic [W_ADDR-1:0]   sl_HADDR;
    logic [W_DATA-1:0]   sl_HWDATA;
    logic                out_sl_HREADY;
    logic [W_RESP-1:0]   out_sl_HRESP;
    logic [W_DATA-1:0]   out_sl_HRDATA;

    modport master (
        output sl_HSEL, sl_HREADY, sl_HWRITE, sl_HTRANS, sl_HBURST, sl_HSIZE, sl_HADDR,
               sl_HWDATA,
        input  out_sl_HREADY, out_sl_HRESP, out_sl_HRDATA
    );

    modport slave (
        input  sl_HSEL, sl_HREADY, sl_HWRITE, sl_HTRANS, sl_HBURST, sl_HSIZE, sl_HADDR,
               sl_HWDATA,
        output out_sl_HREADY, out_sl_HRESP, out_sl_HRDATA
    );
endinterface

// File: rtl/riscv_alu_queue_if.sv
// AHB-lite queued RISC-V ALU coprocessor: command FIFO -> multi-cycle ALU engine -> result FIFO.
// Optional feature macro: ALU_QUEUE_IRQ_EN adds the IE bit and a registered irq_o output.
module riscv_alu_queue_if #(
    parameter int unsigned W_ADDR  = 32,
    parameter int unsigned W_DATA  = 32,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned W_DEPTH = 2,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic                HCLK,
    input  logic                HRESET,
`ifdef ALU_QUEUE_IRQ_EN
    output logic                irq_o,
`endif
    riscv_alu_queue_if_if.slave bus
);

    localparam logic [3:0] RegOp     = 4'h0;
    localparam logic [3:0] RegA      = 4'h1;
    localparam logic [3:0] RegB      = 4'h2;
    localparam logic [3:0] RegCmd    = 4'h3;
    localparam logic [3:0] RegRes    = 4'h4;
    localparam logic [3:0] RegFlags  = 4'h5;
    localparam logic [3:0] RegStatus = 4'h6;
    localparam logic [3:0] RegCtrl   = 4'h7;

    localparam logic [3:0] OpAdd  = 4'h0;
    localparam logic [3:0] OpSll  = 4'h1;
    localparam logic [3:0] OpSlt  = 4'h2;
    localparam logic [3:0] OpSltu = 4'h3;
    localparam logic [3:0] OpXor  = 4'h4;
    localparam logic [3:0] OpSrl  = 4'h5;
    localparam logic [3:0] OpOr   = 4'h6;
    localparam logic [3:0] OpAnd  = 4'h7;
    localparam logic [3:0] OpSub  = 4'h8;
    localparam logic [3:0] OpSra  = 4'hD;

    localparam logic [W_DEPTH:0] FullCnt = (W_DEPTH + 1)'(DEPTH);
    localparam logic [3:0]       LatInit = 4'(ALU_LAT - 1);

    typedef enum logic [0:0] {StIdle, StExec} state_e;

    // Address-phase capture
    logic [3:0]          sel_q;
    logic                wr_q, rd_q;
    logic                addr_valid;
    logic [W_DATA-1:0]   wdata;
    logic [W_DATA-1:0]   rdata;

    // Software-visible registers
    logic [3:0]          op_q;
    logic [31:0]         a_q, b_q;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;
`ifdef ALU_QUEUE_IRQ_EN
    logic                ie_q;
    logic                irq_q;
`endif

    // Command FIFO entries are {op, a, b}
    logic [67:0]         cmd_mem_q [DEPTH];
    logic [W_DEPTH-1:0]  cmd_wptr_q, cmd_rptr_q;
    logic [W_DEPTH:0]    cmd_cnt_q, cmd_cnt_d;

    // Result FIFO entries are {flcnz, result}
    logic [36:0]         res_mem_q [DEPTH];
    logic [W_DEPTH-1:0]  res_wptr_q, res_rptr_q;
    logic [W_DEPTH:0]    res_cnt_q, res_cnt_d;
    logic [36:0]         res_head;

    // Engine
    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [3:0]          alu_op_q;
    logic [31:0]         alu_a_q, alu_b_q;
    logic [31:0]         alu_p;
    logic [4:0]          flcnz;
    logic [32:0]         add_w, sub_w;
    logic                lt_s, fl_c, fl_f;

    // Data-phase decode
    logic                cmd_req, ctrl_wr, flush, res_rd;
    logic                cmd_full, cmd_empty, res_empty;
    logic                cmd_push, dispatch, res_push, res_pop, ovf_set;

    logic                unused_bus;

    assign addr_valid = bus.sl_HSEL & bus.sl_HREADY & bus.sl_HTRANS[1];
    assign wdata      = bus.sl_HWDATA;
    assign unused_bus = ^{bus.sl_HADDR[W_ADDR-1:6], bus.sl_HADDR[1:0], bus.sl_HBURST,
                          bus.sl_HSIZE, bus.sl_HTRANS[0]};

    assign cmd_req   = wr_q & (sel_q == RegCmd);
    assign ctrl_wr   = wr_q & (sel_q == RegCtrl);
    assign flush     = ctrl_wr & wdata[8];
    assign res_rd    = rd_q & (sel_q == RegRes);

    assign cmd_full  = (cmd_cnt_q == FullCnt);
    assign cmd_empty = (cmd_cnt_q == '0);
    assign res_empty = (res_cnt_q == '0);
    assign res_head  = res_mem_q[res_rptr_q];

    // Flush dominates every queue movement in its cycle, including a same-cycle CMD push.
    assign cmd_push  = cmd_req & ~cmd_full & ~flush;
    assign ovf_set   = cmd_req & cmd_full & ~flush;
    assign dispatch  = (state_q == StIdle) & ~cmd_empty & (res_cnt_q < FullCnt) & ~flush;
    assign res_push  = (state_q == StExec) & (cnt_q == '0) & ~flush;
    assign res_pop   = res_rd & ~res_empty & ~flush;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (dispatch) begin
                    state_d = StExec;
                    cnt_d   = LatInit;
                end
            end
            StExec: begin
                if (flush || (cnt_q == '0)) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cmd_cnt_d = cmd_cnt_q;
        unique case ({cmd_push, dispatch})
            2'b10:   cmd_cnt_d = cmd_cnt_q + 1'b1;
            2'b01:   cmd_cnt_d = cmd_cnt_q - 1'b1;
            default: cmd_cnt_d = cmd_cnt_q;
        endcase
        res_cnt_d = res_cnt_q;
        unique case ({res_push, res_pop})
            2'b10:   res_cnt_d = res_cnt_q + 1'b1;
            2'b01:   res_cnt_d = res_cnt_q - 1'b1;
            default: res_cnt_d = res_cnt_q;
        endcase
    end

    always_comb begin
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (ctrl_wr && wdata[0]) ovf_d = 1'b0;
        if (ctrl_wr && wdata[1]) unf_d = 1'b0;
        if (ovf_set) ovf_d = 1'b1;
        if (res_rd && res_empty) unf_d = 1'b1;
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            sel_q      <= '0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            cmd_wptr_q <= '0;
            cmd_rptr_q <= '0;
            cmd_cnt_q  <= '0;
            res_wptr_q <= '0;
            res_rptr_q <= '0;
            res_cnt_q  <= '0;
            state_q    <= StIdle;
            cnt_q      <= '0;
            alu_op_q   <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
        end else begin
            if (addr_valid) begin
                sel_q <= bus.sl_HADDR[5:2];
                wr_q  <= bus.sl_HWRITE;
                rd_q  <= ~bus.sl_HWRITE;
            end else begin
                wr_q  <= 1'b0;
                rd_q  <= 1'b0;
            end
            if (wr_q && (sel_q == RegOp)) op_q <= wdata[3:0];
            if (wr_q && (sel_q == RegA))  a_q  <= wdata[31:0];
            if (wr_q && (sel_q == RegB))  b_q  <= wdata[31:0];
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (dispatch) begin
                {alu_op_q, alu_a_q, alu_b_q} <= cmd_mem_q[cmd_rptr_q];
            end
            if (flush) begin
                cmd_wptr_q <= '0;
                cmd_rptr_q <= '0;
                cmd_cnt_q  <= '0;
                res_wptr_q <= '0;
                res_rptr_q <= '0;
                res_cnt_q  <= '0;
            end else begin
                if (cmd_push) cmd_wptr_q <= cmd_wptr_q + 1'b1;
                if (dispatch) cmd_rptr_q <= cmd_rptr_q + 1'b1;
                if (res_push) res_wptr_q <= res_wptr_q + 1'b1;
                if (res_pop)  res_rptr_q <= res_rptr_q + 1'b1;
                cmd_cnt_q <= cmd_cnt_d;
                res_cnt_q <= res_cnt_d;
            end
        end
    end

    // Storage is never read before written, so it carries no reset.
    always_ff @(posedge HCLK) begin
        if (cmd_push) cmd_mem_q[cmd_wptr_q] <= {op_q, a_q, b_q};
        if (res_push) res_mem_q[res_wptr_q] <= {flcnz, alu_p};
    end

`ifdef ALU_QUEUE_IRQ_EN
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            ie_q  <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            if (ctrl_wr) ie_q <= wdata[2];
            irq_q <= ie_q & ((res_cnt_q != '0) | ovf_q | unf_q);
        end
    end

    assign irq_o = irq_q;
`endif

    // ALU datapath; flcnz = {signed overflow, signed less-than, carry, negative, zero}
    always_comb begin
        add_w = {1'b0, alu_a_q} + {1'b0, alu_b_q};
        sub_w = {1'b0, alu_a_q} + {1'b0, ~alu_b_q} + 33'd1;
        lt_s  = $signed(alu_a_q) < $signed(alu_b_q);
        alu_p = '0;
        fl_c  = 1'b0;
        fl_f  = 1'b0;
        case (alu_op_q)
            OpAdd: begin
                alu_p = add_w[31:0];
                fl_c  = add_w[32];
                fl_f  = (alu_a_q[31] == alu_b_q[31]) && (add_w[31] != alu_a_q[31]);
            end
            OpSub: begin
                alu_p = sub_w[31:0];
                fl_c  = sub_w[32];
                fl_f  = (alu_a_q[31] != alu_b_q[31]) && (sub_w[31] != alu_a_q[31]);
            end
            OpSll:   alu_p = alu_a_q << alu_b_q[4:0];
            OpSlt:   alu_p = {31'b0, lt_s};
            OpSltu:  alu_p = {31'b0, (alu_a_q < alu_b_q)};
            OpXor:   alu_p = alu_a_q ^ alu_b_q;
            OpSrl:   alu_p = alu_a_q >> alu_b_q[4:0];
            OpSra:   alu_p = $signed(alu_a_q) >>> alu_b_q[4:0];
            OpOr:    alu_p = alu_a_q | alu_b_q;
            OpAnd:   alu_p = alu_a_q & alu_b_q;
            default: alu_p = '0;
        endcase
    end

    assign flcnz = {fl_f, lt_s, fl_c, alu_p[31], (alu_p == '0)};

    always_comb begin
        rdata = '0;
        case (sel_q)
            RegOp:    rdata[3:0]  = op_q;
            RegA:     rdata[31:0] = a_q;
            RegB:     rdata[31:0] = b_q;
            RegRes:   rdata[31:0] = res_empty ? 32'h0 : res_head[31:0];
            RegFlags: rdata[4:0]  = res_empty ? 5'h0 : res_head[36:32];
            RegStatus: begin
                rdata[W_DEPTH:0]     = cmd_cnt_q;
                rdata[8+W_DEPTH:8]   = res_cnt_q;
                rdata[16]            = (state_q != StIdle);
                rdata[17]            = cmd_full;
                rdata[18]            = res_empty;
                rdata[24]            = ovf_q;
                rdata[25]            = unf_q;
            end
            RegCtrl: begin
`ifdef ALU_QUEUE_IRQ_EN
                rdata[2] = ie_q;
`else
                rdata[2] = 1'b0;
`endif
            end
            default: rdata = '0;
        endcase
    end

    assign bus.out_sl_HRDATA = rdata;
    assign bus.out_sl_HREADY = 1'b1;
    assign bus.out_sl_HRESP  = '0;

endmodule

// File: tb/tb_riscv_alu_queue_if.sv
// Self-checking bench for riscv_alu_queue_if: directed register/queue scenarios plus random
// ALU jobs compared against an arithmetic reference model.
module tb_riscv_alu_queue_if;

    localparam logic [31:0] AOp = 32'h00, AA = 32'h04, AB = 32'h08, ACmd = 32'h0C;
    localparam logic [31:0] ARes = 32'h10, AFlags = 32'h14, AStat = 32'h18, ACtrl = 32'h1C;
    localparam longint SMax = 64'sd2147483647;
    localparam longint SMin = -64'sd2147483648;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic irq;
    int   errors = 0;
    int   checks = 0;

    logic        p_wr [8];
    logic [31:0] p_ad [8];
    logic [31:0] p_wd [8];
    logic [31:0] p_rd [8];

    int unsigned op_tbl [11] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 13, 9};
    logic [31:0] edge_tbl [4] = '{32'h0, 32'h7fff_ffff, 32'h8000_0000, 32'hffff_ffff};

    riscv_alu_queue_if_if bus_if ();

    riscv_alu_queue_if #(
        .W_ADDR (32),
        .W_DATA (32),
        .DEPTH  (4),
        .W_DEPTH(2),
        .ALU_LAT(3)
    ) dut (
        .HCLK  (clk),
        .HRESET(rst),
`ifdef ALU_QUEUE_IRQ_EN
        .irq_o (irq),
`endif
        .bus   (bus_if)
    );

`ifndef ALU_QUEUE_IRQ_EN
    assign irq = 1'b0;
`endif

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_p(input int k, input logic w, input logic [31:0] a, input logic [31:0] d);
        p_wr[k] = w;
        p_ad[k] = a;
        p_wd[k] = d;
    endtask

    // Back-to-back pipelined transfers; p_rd[k] samples HRDATA in transfer k's data phase.
    task automatic pipe(input int n);
        bus_if.sl_HSEL   = 1'b1;
        bus_if.sl_HTRANS = 2'b10;
        bus_if.sl_HWRITE = p_wr[0];
        bus_if.sl_HADDR  = p_ad[0];
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            bus_if.sl_HWDATA = p_wd[k];
            p_rd[k] = bus_if.out_sl_HRDATA;
            if (k + 1 < n) begin
                bus_if.sl_HWRITE = p_wr[k+1];
                bus_if.sl_HADDR  = p_ad[k+1];
            end else begin
                bus_if.sl_HSEL   = 1'b0;
                bus_if.sl_HTRANS = 2'b00;
                bus_if.sl_HWRITE = 1'b0;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        set_p(0, 1'b1, a, d);
        pipe(1);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        set_p(0, 1'b0, a, 32'h0);
        pipe(1);
        d = p_rd[0];
    endtask

    task automatic wait_res(input string tag, input int want);
        logic [31:0] s;
        s = 32'h0;
        for (int i = 0; i < 60; i++) begin
            rd(AStat, s);
            if (int'(s[10:8]) >= want) break;
        end
        chk(tag, {31'b0, int'(s[10:8]) >= want}, 32'd1);
    endtask

    function automatic void ref_alu(input logic [3:0] op, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] r,
                                    output logic [4:0] fl);
        longint ua, ub, sa, sb, s;
        bit c, f;
        int sh;
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(b[4:0]);
        c = 1'b0;
        f = 1'b0;
        r = 32'h0;
        case (op)
            4'd0: begin
                s = ua + ub; r = s[31:0]; c = (s > 64'hffff_ffff);
                s = sa + sb; f = (s > SMax) || (s < SMin);
            end
            4'd8: begin
                s = ua - ub; r = s[31:0]; c = (ua >= ub);
                s = sa - sb; f = (s > SMax) || (s < SMin);
            end
            4'd1:    r = a << sh;
            4'd2:    r = (sa < sb) ? 32'd1 : 32'd0;
            4'd3:    r = (ua < ub) ? 32'd1 : 32'd0;
            4'd4:    r = a ^ b;
            4'd5:    r = a >> sh;
            4'd13:   begin s = sa >>> sh; r = s[31:0]; end
            4'd6:    r = a | b;
            4'd7:    r = a & b;
            default: r = 32'h0;
        endcase
        fl = {f, (sa < sb), c, r[31], (r == 32'h0)};
    endfunction

    task automatic run_job(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, output logic [31:0] got);
        logic [31:0] fl_got, r_exp;
        logic [4:0]  fl_exp;
        set_p(0, 1'b1, AOp, {28'h0, op});
        set_p(1, 1'b1, AA, a);
        set_p(2, 1'b1, AB, b);
        set_p(3, 1'b1, ACmd, 32'h0);
        pipe(4);
        wait_res({tag, "_wait"}, 1);
        rd(AFlags, fl_got);
        rd(ARes, got);
        ref_alu(op, a, b, r_exp, fl_exp);
        chk({tag, "_flags"}, fl_got, {27'h0, fl_exp});
        chk({tag, "_result"}, got, r_exp);
    endtask

    initial begin
        logic [31:0] d, a, b;
        logic [3:0]  op;
        bus_if.sl_HSEL   = 1'b0;
        bus_if.sl_HREADY = 1'b1;
        bus_if.sl_HWRITE = 1'b0;
        bus_if.sl_HTRANS = 2'b00;
        bus_if.sl_HBURST = 3'b000;
        bus_if.sl_HSIZE  = 3'b010;
        bus_if.sl_HADDR  = 32'h0;
        bus_if.sl_HWDATA = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        chk("rst_hrdata", bus_if.out_sl_HRDATA, 32'h0);
        chk("hready", {31'b0, bus_if.out_sl_HREADY}, 32'd1);
        chk("hresp", {30'b0, bus_if.out_sl_HRESP}, 32'd0);
        chk("rst_irq", {31'b0, irq}, 32'd0);
        rd(AStat, d);
        chk("rst_status", d, 32'h0004_0000);
        rd(ACtrl, d);
        chk("rst_ctrl", d, 32'h0);

        // Register access and unmapped offsets
        wr(AOp, 32'hFFFF_FFA5);
        rd(AOp, d);
        chk("op_rw", d, 32'h5);
        wr(AB, 32'hDEAD_BEEF);
        rd(AB, d);
        chk("b_rw", d, 32'hDEAD_BEEF);
        wr(32'h24, 32'h1234_5678);
        rd(32'h24, d);
        chk("unmapped", d, 32'h0);
        rd(ACmd, d);
        chk("cmd_reads0", d, 32'h0);

        // Single add
        run_job("add", 4'd0, 32'd5, 32'd7, d);
        chk("add_12", d, 32'd12);
        rd(AStat, d);
        chk("add_empty", {31'b0, d[18]}, 32'd1);

        // Latency: CMD data phase at T, STATUS reads in T+1..T+6
        set_p(0, 1'b1, ACmd, 32'h0);
        for (int k = 1; k < 7; k++) set_p(k, 1'b0, AStat, 32'h0);
        pipe(7);
        chk("lat_t4", {29'b0, p_rd[4][10:8]}, 32'd0);
        chk("lat_t5", {29'b0, p_rd[5][10:8]}, 32'd1);
        rd(ARes, d);
        chk("lat_res", d, 32'd12);

        // Queue fill: result FIFO fills, engine stalls, command FIFO fills, one dropped
        wr(AOp, 32'h0);
        wr(AB, 32'h1);
        for (int i = 1; i <= 4; i++) begin
            set_p(0, 1'b1, AA, i);
            set_p(1, 1'b1, ACmd, 32'h0);
            pipe(2);
        end
        wait_res("fill_wait", 4);
        for (int i = 5; i <= 9; i++) begin
            set_p(0, 1'b1, AA, i);
            set_p(1, 1'b1, ACmd, 32'h0);
            pipe(2);
        end
        rd(AStat, d);
        chk("fill_status", d, 32'h0102_0404);
        for (int i = 1; i <= 8; i++) begin
            wait_res("drain_wait", 1);
            rd(ARes, d);
            chk("drain_order", d, i + 1);
        end
        rd(AStat, d);
        chk("drain_status", d, 32'h0104_0000);
        wr(ACtrl, 32'h1);
        rd(AStat, d);
        chk("ovf_clear", d, 32'h0004_0000);

        // Underflow
        rd(ARes, d);
        chk("unf_data", d, 32'h0);
        rd(AStat, d);
        chk("unf_status", d, 32'h0204_0000);

        // Flush mid-job with two commands queued; UNF must survive it
        wr(AA, 32'd3);
        wr(AB, 32'd4);
        set_p(0, 1'b1, ACmd, 32'h0);
        set_p(1, 1'b1, ACmd, 32'h0);
        set_p(2, 1'b1, ACmd, 32'h0);
        set_p(3, 1'b1, ACtrl, 32'h100);
        set_p(4, 1'b0, AStat, 32'h0);
        pipe(5);
        chk("flush_status", p_rd[4], 32'h0204_0000);
        repeat (10) @(posedge clk);
        #1;
        rd(AStat, d);
        chk("flush_quiet", d, 32'h0204_0000);
        wr(ACtrl, 32'h2);
        rd(AStat, d);
        chk("unf_clear", d, 32'h0004_0000);

        // Random jobs against the reference model
        for (int n = 0; n < 12; n++) begin
            op = 4'(op_tbl[$urandom_range(0, 10)]);
            a  = $urandom();
            b  = $urandom();
            if ($urandom_range(0, 3) == 0) a = edge_tbl[$urandom_range(0, 3)];
            if ($urandom_range(0, 3) == 0) b = edge_tbl[$urandom_range(0, 3)];
            run_job("rand", op, a, b, d);
        end

`ifdef ALU_QUEUE_IRQ_EN
        wr(ACtrl, 32'h4);
        rd(ACtrl, d);
        chk("ie_rw", d, 32'h4);
        chk("irq_idle", {31'b0, irq}, 32'd0);
        wr(ACmd, 32'h0);
        for (int i = 0; i < 20; i++) begin
            if (irq) break;
            @(posedge clk); #1;
        end
        chk("irq_rise", {31'b0, irq}, 32'd1);
        rd(ARes, d);
        repeat (2) @(posedge clk);
        #1;
        chk("irq_fall", {31'b0, irq}, 32'd0);
        wr(ACtrl, 32'h0);
`endif

        // Reset asserted mid-job aborts it
        set_p(0, 1'b1, AA, 32'd9);
        set_p(1, 1'b1, ACmd, 32'h0);
        pipe(2);
        @(posedge clk); #1;
        rst = 1'b1;
        #2;
        chk("rst_async", bus_if.out_sl_HRDATA, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rd(AStat, d);
        chk("rst_mid_status", d, 32'h0004_0000);
        rd(AA, d);
        chk("rst_mid_a", d, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/riscv_alu_queue_if.md
# riscv_alu_queue_if

AHB-lite slave that turns the standalone RISC-V ALU into a queued coprocessor. The bus writes operands and an opcode, then a CMD write enqueues the job into a DEPTH-entry command FIFO. A sequential engine drains the queue through one `riscv_alu` instance with a configurable multi-cycle latency and pushes {flags, result} into a DEPTH-entry result FIFO. Software pops results and status over the same slave port.

## Interface
- `W_ADDR`, 32, HADDR width
- `W_DATA`, 32, bus data width; fixed to the 32-bit ALU datapath
- `DEPTH`, 4, entries per FIFO; power of two, 2..128
- `W_DEPTH`, 2, log2(DEPTH)
- `ALU_LAT`, 1, engine cycles per job, 1..15
- `HCLK` in 1: single clock, all logic on rising edge
- `HRESET` in 1: asynchronous, active-high reset
- `sl_HSEL`, `sl_HREADY`, `sl_HWRITE` in 1: standard AHB-lite slave controls
- `sl_HTRANS` in `W_TRANS`: standard AHB-lite slave control
- `sl_HBURST` in `W_BURST`: standard AHB-lite slave control
- `sl_HSIZE` in `W_SIZE`: standard AHB-lite slave control
- `sl_HADDR` in W_ADDR, `sl_HWDATA` in W_DATA: address and write data
- `out_sl_HREADY` out 1: constant 1, no wait states
- `out_sl_HRESP` out `W_RESP`: constant `RESP_OKAY`
- `out_sl_HRDATA` out W_DATA: read data, combinational in the data phase
- `irq_o` out 1: present only with `ALU_QUEUE_IRQ_EN`

## Operation
- **Address phase capture.** When HSEL, HREADY and HTRANS is NONSEQ or SEQ, the block registers HADDR[5:2] as the selected register, plus write and read flags. Otherwise both flags are cleared.
- **Register map** (unlisted offsets 0x20–0x3C read 0 and ignore writes):
  - 0x00 OP: RW, bits [3:0].
  - 0x04 A: RW.
  - 0x08 B: RW.
  - 0x0C CMD: WO, reads 0. A write of any value pushes {OP, A, B} into the command FIFO, using the register values as they stand at the write data phase.
  - 0x10 RESULT: RO. Returns the result-FIFO head. A read pops the head if the FIFO is non-empty. A read while empty returns 0 and sets the sticky UNF bit.
  - 0x14 FLAGS: RO. Returns the 5-bit `flcnz` of the head in bits [4:0]. Does not pop.
  - 0x18 STATUS: RO.
    - [W_DEPTH:0] command count.
    - [8+W_DEPTH:8] result count.
    - [16] busy, meaning the engine is not in IDLE.
    - [17] command FIFO full.
    - [18] result FIFO empty.
    - [24] OVF.
    - [25] UNF.
  - 0x1C CTRL: WO, reads 0 except bit 2.
    - Bit 0 = 1 clears OVF.
    - Bit 1 = 1 clears UNF.
    - Bit 2 is IE (RW).
    - Bit 8 = 1 triggers a flush.
- **Command push while full.** A CMD write while the command FIFO is full is dropped and sets OVF. Full is evaluated before any same-cycle pop, so there is no bypass.
- **Engine FSM:**
  - IDLE → EXEC when the command FIFO is non-empty and the result FIFO has room for one more entry (result count < DEPTH). On this transition the engine pops the command, latches OP/A/B into the ALU inputs and loads the counter with ALU_LAT-1.
  - EXEC decrements the counter each cycle.
  - At counter 0, EXEC pushes {`flcnz`, `alu_p_o`} into the result FIFO and returns to IDLE.
- **Result FIFO overflow.** Because space is checked at dispatch, the result FIFO never overflows.
- **Simultaneous events:**
  - A bus pop and an engine push in the same cycle on the result FIFO both take effect.
  - A bus push and an engine pop in the same cycle on the command FIFO both take effect, provided the FIFO was not full.
- **Flush:**
  - Empties both FIFOs and returns the engine to IDLE.
  - The in-flight result is discarded.
  - OVF and UNF are unchanged.
  - A same-cycle CMD push is discarded without setting OVF.
- **Wrap-around.** Pointers are W_DEPTH bits and wrap modulo DEPTH. Counts are W_DEPTH+1 bits.

## Timing
- **Reset values:**
  - All registers, pointers, counts, OVF, UNF and IE are 0.
  - The engine is in IDLE.
  - `out_sl_HRDATA` is 0 while the selected register is 0x00 and OP is 0.
  - `irq_o` is 0.
- **Reset mid-job.** Reset asserted mid-job aborts it asynchronously. No result is produced.
- **Write latency.** Register writes take effect at the rising edge ending the data phase.
- **CMD-to-result latency.** For a CMD data phase in cycle T with an idle engine and empty FIFOs:
  - Pop and dispatch happen in cycle T+1.
  - EXEC runs in cycles T+2 .. T+1+ALU_LAT.
  - The result is pushed at the end of cycle T+1+ALU_LAT.
  - The result is readable in a data phase at cycle T+2+ALU_LAT or later.
- **Throughput.** One job per ALU_LAT+1 cycles.

## Configuration
- `ALU_QUEUE_IRQ_EN` defined:
  - `irq_o` is a registered output: IE & (result count != 0 | OVF | UNF), updated every cycle.
  - CTRL bit 2 is implemented.
- `ALU_QUEUE_IRQ_EN` undefined:
  - No `irq_o` port.
  - The IE flop is absent and CTRL bit 2 reads 0.

## Test plan
- **Single add.** Reset, then write OP = ADD, A = 5, B = 7, then write CMD. Poll STATUS until result count = 1. Read FLAGS, then RESULT → 12. Afterwards STATUS[18] = 1.
- **Queue fill and order.** Write DEPTH+1 CMDs back-to-back with A = 1..DEPTH+1, B = 1. With the engine stalled on a full result FIFO, expect OVF = 1. The DEPTH results are returned in order.
- **Underflow.** Read RESULT while empty → 0 and UNF = 1. Write CTRL = 0x2 → UNF = 0.
- **Latency.** With ALU_LAT = 3, a CMD in cycle T makes STATUS result count = 1 first observable in cycle T+5.
- **Flush mid-job.** While the engine is in EXEC with 2 commands queued, write CTRL = 0x100. Expect both counts = 0, busy = 0, and no result pushed afterwards.
- **IRQ (macro defined).** With IE = 1, `irq_o` rises one cycle after the result push. It falls one cycle after the pop that empties the FIFO.
